// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon byte-to-block packer.
package ascon_pack;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    PAD_EXTRA = 2'd1,
    HOLD      = 2'd2
  } packer_state_t;

  localparam logic [7:0]  PAD_BYTE  = 8'h80;
  localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

  // Position a byte at slot k of a block, slot 0 being the most significant byte.
  function automatic logic [63:0] place_byte(input logic [7:0] b, input logic [2:0] k);
    place_byte = {56'd0, b} << (6'd56 - {k, 3'b000});
  endfunction

endpackage

// File: rtl/ascon_block_packer.sv
// Ascon byte-to-block packer: gathers plaintext bytes into 64-bit blocks,
// applies 10* padding to the final block, and presents the result through a
// valid/ready output register.
// Optional feature: define ASCON_PACKER_COUNT_EN to add block_count_o, a
// 16-bit wrapping count of transferred blocks.
module ascon_block_packer
  import ascon_pack::*;
(
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic [63:0] block_o,
  output logic        block_valid_o,
  output logic        block_last_o,
  input  logic        block_ready_i
`ifdef ASCON_PACKER_COUNT_EN
  ,
  output logic [15:0] block_count_o
`endif
);

  packer_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [63:0]   asm_q, asm_d;
  logic          hold_last_q, hold_last_d;   // pending block in asm_q is the final one
  logic          hold_pad_q, hold_pad_d;     // pending block must be followed by PAD_BLOCK
  logic [63:0]   blk_d;
  logic          blk_valid_d, blk_last_d;

  logic          accept_s, xfer_s, out_free_s;
  logic          complete_s, done_last_s, done_pad_s;
  logic [63:0]   merged_s, done_blk_s;

  assign byte_ready_o = (state_q == FILL) && !resetb_i;
  assign accept_s     = byte_valid_i && byte_ready_o;
  assign xfer_s       = block_valid_o && block_ready_i;
  assign out_free_s   = !block_valid_o || block_ready_i;
  assign merged_s     = asm_q | place_byte(byte_i, idx_q);

  // Classify the accepted byte: does it complete a block, and how is that block finished.
  always_comb begin
    complete_s  = 1'b0;
    done_last_s = 1'b0;
    done_pad_s  = 1'b0;
    done_blk_s  = merged_s;
    if (accept_s && byte_last_i && (idx_q != 3'd7)) begin
      complete_s  = 1'b1;
      done_last_s = 1'b1;
      done_blk_s  = merged_s | place_byte(PAD_BYTE, idx_q + 3'd1);
    end else if (accept_s && (idx_q == 3'd7)) begin
      complete_s  = 1'b1;
      done_pad_s  = byte_last_i;
    end else begin
      complete_s  = 1'b0;
    end
  end

  // Next-state and datapath update for the FSM, assembly and output register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    hold_last_d = hold_last_q;
    hold_pad_d  = hold_pad_q;
    blk_d       = block_o;
    blk_valid_d = block_valid_o && !block_ready_i;
    blk_last_d  = block_last_o;
    case (state_q)
      FILL: begin
        if (complete_s) begin
          idx_d = 3'd0;
          if (out_free_s) begin
            blk_d       = done_blk_s;
            blk_valid_d = 1'b1;
            blk_last_d  = done_last_s;
            asm_d       = 64'd0;
            state_d     = done_pad_s ? PAD_EXTRA : FILL;
          end else begin
            asm_d       = done_blk_s;
            hold_last_d = done_last_s;
            hold_pad_d  = done_pad_s;
            state_d     = HOLD;
          end
        end else if (accept_s) begin
          asm_d = merged_s;
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (out_free_s) begin
          blk_d       = asm_q;
          blk_valid_d = 1'b1;
          blk_last_d  = hold_last_q;
          asm_d       = 64'd0;
          state_d     = hold_pad_q ? PAD_EXTRA : FILL;
        end else begin
          state_d = HOLD;
        end
      end
      PAD_EXTRA: begin
        if (out_free_s) begin
          blk_d       = PAD_BLOCK;
          blk_valid_d = 1'b1;
          blk_last_d  = 1'b1;
          state_d     = FILL;
        end else begin
          state_d = PAD_EXTRA;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, assembly and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q       <= FILL;
      idx_q         <= 3'd0;
      asm_q         <= 64'd0;
      hold_last_q   <= 1'b0;
      hold_pad_q    <= 1'b0;
      block_o       <= 64'd0;
      block_valid_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      hold_last_q   <= hold_last_d;
      hold_pad_q    <= hold_pad_d;
      block_o       <= blk_d;
      block_valid_o <= blk_valid_d;
      block_last_o  <= blk_last_d;
    end
  end

`ifdef ASCON_PACKER_COUNT_EN
  // Count every block handed downstream; wraps naturally at 16 bits.
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      block_count_o <= 16'd0;
    end else if (xfer_s) begin
      block_count_o <= block_count_o + 16'd1;
    end else begin
      block_count_o <= block_count_o;
    end
  end
`else
  logic unused_xfer_s;
  assign unused_xfer_s = xfer_s;
`endif

endmodule

// File: tb/tb_ascon_block_packer.sv
// Self-checking bench for ascon_block_packer: directed scenarios plus random
// messages checked against a message-level packing/padding model.
// Build with ASCON_PACKER_COUNT_EN defined to also exercise block_count_o.
module tb_ascon_block_packer;

  logic        clock_i = 1'b0;
  logic        resetb_i = 1'b1;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_last_i = 1'b0;
  logic        byte_ready_o;
  logic [63:0] block_o;
  logic        block_valid_o;
  logic        block_last_o;
  logic        block_ready_i = 1'b1;
`ifdef ASCON_PACKER_COUNT_EN
  logic [15:0] block_count_o;
`endif

  ascon_block_packer dut (
    .clock_i       (clock_i),
    .resetb_i      (resetb_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_last_i   (byte_last_i),
    .byte_ready_o  (byte_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_last_o  (block_last_o),
    .block_ready_i (block_ready_i)
`ifdef ASCON_PACKER_COUNT_EN
    ,
    .block_count_o (block_count_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [64:0] exp_q[$];      // {last, block} expected in transfer order
  logic [7:0]  cur_q[$];      // bytes of the block currently being gathered
  logic        acc_flag = 1'b0;
  logic        rand_rdy = 1'b0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_blk = 64'd0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a message is cut into 8-byte blocks; the tail gets 0x80
  // then zeros, and a message of whole blocks gets an extra 0x80.. block.
  task automatic model_push(input logic [7:0] b, input logic last);
    logic [63:0] blk;
    cur_q.push_back(b);
    if (last || cur_q.size() == 8) begin
      blk = 64'd0;
      for (int i = 0; i < cur_q.size(); i++)
        blk = blk | (64'(cur_q[i]) << (8 * (7 - i)));
      if (cur_q.size() < 8) begin
        blk = blk | (64'h80 << (8 * (7 - cur_q.size())));
        exp_q.push_back({1'b1, blk});
      end else begin
        exp_q.push_back({1'b0, blk});
        if (last) exp_q.push_back({1'b1, 64'h8000_0000_0000_0000});
      end
      cur_q.delete();
    end
  endtask

  // One clock: observe the handshakes just before the edge, then step to the next falling edge.
  task automatic cycle();
    logic [64:0] e;
    #1;
    acc_flag = 1'b0;
    if (!resetb_i) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(block_valid_o), 64'd1);
        chk("hold_blk", block_o, prev_blk);
        chk("hold_last", 64'(block_last_o), 64'(prev_last));
      end
      if (block_valid_o && block_ready_i) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexp_xfer", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("blk", block_o, e[63:0]);
          chk("blk_last", 64'(block_last_o), 64'(e[64]));
        end
      end
      acc_flag = byte_valid_i && byte_ready_o;
      if (acc_flag) model_push(byte_i, byte_last_i);
      prev_hold = block_valid_o && !block_ready_i;
      prev_blk  = block_o;
      prev_last = block_last_o;
    end else begin
      cur_q.delete();
      exp_q.delete();
      n_xfer    = 0;
      prev_hold = 1'b0;
    end
    @(posedge clock_i);
    @(negedge clock_i);
    if (rand_rdy) block_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic got;
    byte_i       = b;
    byte_last_i  = last;
    byte_valid_i = 1'b1;
    got          = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      cycle();
      got = acc_flag;
    end
    chk("byte_acc", 64'(got), 64'd1);
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic drain();
    byte_valid_i = 1'b0;
    for (int t = 0; t < 500 && exp_q.size() > 0; t++) cycle();
    chk("drain", 64'(exp_q.size()), 64'd0);
    cycle();
  endtask

  initial begin
    logic [7:0] msg1 [6];
    int len;
    msg1 = '{8'h41, 8'h20, 8'h74, 8'h6F, 8'h20, 8'h42};

    // Reset state
    @(negedge clock_i);
    repeat (3) cycle();
    #1;
    chk("rst_ready", 64'(byte_ready_o), 64'd0);
    chk("rst_valid", 64'(block_valid_o), 64'd0);
    chk("rst_blk", block_o, 64'd0);
    chk("rst_last", 64'(block_last_o), 64'd0);
    resetb_i = 1'b0;
    cycle();

    // Six-byte message padded inside its block, one cycle latency
    for (int i = 0; i < 6; i++) send_byte(msg1[i], i == 5);
    #1;
    chk("t1_lat", 64'(block_valid_o), 64'd1);
    chk("t1_blk", block_o, 64'h4120_746F_2042_8000);
    chk("t1_last", 64'(block_last_o), 64'd1);
    drain();

    // Eight-byte message needs a separate padding block
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    #1;
    chk("t2_blk", block_o, 64'h0001_0203_0405_0607);
    chk("t2_last", 64'(block_last_o), 64'd0);
    chk("t2_rdy_pad", 64'(byte_ready_o), 64'd0);
    drain();
`ifdef ASCON_PACKER_COUNT_EN
    chk("t6_count", 64'(block_count_o), 64'd3);
`endif

    // Back-pressure: 16 bytes with downstream stalled
    block_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    #1;
    chk("t3_rdy_hold", 64'(byte_ready_o), 64'd0);
    chk("t3_held", block_o, 64'h1011_1213_1415_1617);
    repeat (3) cycle();
    block_ready_i = 1'b1;
    cycle();
    #1;
    chk("t3_b2b", 64'(block_valid_o), 64'd1);
    chk("t3_blk2", block_o, 64'h1819_1A1B_1C1D_1E1F);
    drain();
    send_byte(8'h55, 1'b1);
    drain();

    // Reset mid-message discards the partial block
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 1'b0);
    resetb_i = 1'b1;
    repeat (2) cycle();
    resetb_i = 1'b0;
    #1;
    chk("t4_novalid", 64'(block_valid_o), 64'd0);
    repeat (3) cycle();
    chk("t4_nox", 64'(n_xfer), 64'd0);
    send_byte(8'hAA, 1'b1);
    #1;
    chk("t4_blk", block_o, 64'hAA80_0000_0000_0000);
    drain();

    // Two one-byte messages back to back
    send_byte(8'h41, 1'b1);
    #1;
    chk("t5_blk1", block_o, 64'h4180_0000_0000_0000);
    send_byte(8'h42, 1'b1);
    #1;
    chk("t5_blk2", block_o, 64'h4280_0000_0000_0000);
    chk("t5_valid2", 64'(block_valid_o), 64'd1);
    drain();

    // Random messages, random gaps, random downstream stalls
    rand_rdy = 1'b1;
    for (int m = 0; m < 150; m++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cycle();
        send_byte(8'($urandom), i == len - 1);
      end
    end
    rand_rdy = 1'b0;
    block_ready_i = 1'b1;
    drain();
`ifdef ASCON_PACKER_COUNT_EN
    chk("count_final", 64'(block_count_o), 64'(16'(n_xfer)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ascon_block_packer.md
ASCON_BLOCK_PACKER -- requirements
Module: ascon_block_packer

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 clock_i  input  1  rising-edge clock.
REQ-003 resetb_i  input  1  synchronous reset, active-high despite the b suffix.
REQ-004 byte_i  input  8  plaintext byte; the first byte of a message is the first byte accepted.
REQ-005 byte_valid_i  input  1  byte_i and byte_last_i are valid this cycle.
REQ-006 byte_last_i  input  1  the current byte is the final byte of the message; it is ignored unless byte_valid_i=1.
REQ-007 byte_ready_o  output  1  the packer accepts a byte this cycle.
REQ-008 block_o  output  64  packed and padded block for the ascon_top data_i port.
REQ-009 block_valid_o  output  1  block_o is valid; it drives data_valid_i.
REQ-010 block_last_o  output  1  block_o is the final padded block of the message.
REQ-011 block_ready_i  input  1  downstream consumes block_o this cycle.

Function
REQ-012 A byte SHALL be accepted iff byte_valid_i and byte_ready_o are both 1; a block SHALL transfer iff block_valid_o and block_ready_i are both 1.
REQ-013 Byte k of a block (k=0..7) SHALL occupy block_o[63-8k:56-8k], with the first byte at the MSB.
REQ-014 Datapath: a 3-bit byte index plus a 64-bit assembly register, feeding a 64-bit output register with valid and last flags.
REQ-015 FSM states SHALL be FILL, PAD_EXTRA and HOLD.
- FILL collects bytes.
- HOLD is entered when the assembly is complete and the output register is occupied and not draining.
- PAD_EXTRA emits the full padding block.
REQ-016 On acceptance of the 8th byte with byte_last_i=0, the assembled block SHALL load the output register on the next edge, provided the output register is empty or transferring that cycle; otherwise the FSM enters HOLD.
REQ-017 On acceptance of a last byte at index k<7, the assembly SHALL complete the block as follows:
- 0x80 in byte k+1;
- zeros in the remaining bytes;
- block_last_o=1.
REQ-018 On acceptance of a last byte at index 7, the full data block SHALL be emitted with block_last_o=0, followed by the block 64'h8000_0000_0000_0000 with block_last_o=1; the FSM passes through PAD_EXTRA.
REQ-019 byte_ready_o SHALL be 0 in HOLD and PAD_EXTRA, and 1 in FILL.
REQ-020 Latency: block_valid_o SHALL rise the cycle after the completing byte is accepted, when the output register is free.
REQ-021 When the output register transfers and a new block completes in the same cycle, the new block SHALL load with no bubble.
REQ-022 block_o, block_valid_o and block_last_o SHALL hold stable while block_valid_o=1 and block_ready_i=0.
REQ-023 After a block with block_last_o=1 is loaded, the byte index SHALL return to 0 and a new message may begin immediately.
REQ-024 Messages SHALL contain at least one byte; empty-message handling is out of scope.

Reset
REQ-025 While resetb_i=1, all of the following SHALL be 0 on the next edge:
- FSM state = FILL;
- byte index;
- assembly register;
- block_o, block_valid_o and block_last_o.
REQ-026 byte_ready_o SHALL read 0 while resetb_i=1.
REQ-027 A reset mid-message SHALL discard all partial and pending blocks with no output.

Configuration
REQ-028 Macro ASCON_PACKER_COUNT_EN SHALL add the output block_count_o (16 bits).
- It increments by 1 on each block transfer and wraps 16'hFFFF to 0.
- It is reset to 0.
REQ-029 Without ASCON_PACKER_COUNT_EN, the port and the counter SHALL be absent and the behaviour SHALL be otherwise identical.

Structure
REQ-030 The following SHALL reside in ascon_pack:
- the FSM state enum packer_state_t (FILL, PAD_EXTRA, HOLD);
- constant PAD_BYTE = 8'h80;
- constant PAD_BLOCK = 64'h8000_0000_0000_0000.
REQ-031 The implementation SHALL be a single module with no sub-module; the output register stage SHALL be inline.

Verification
REQ-032 Test 1: bytes 41 20 74 6F 20 42 with last on 42, block_ready_i=1 -> one block 64'h4120_746F_2042_8000 with block_last_o=1, one cycle after the byte 42.
REQ-033 Test 2: 8 bytes 00..07 with last on 07 -> block 64'h0001_0203_0405_0607 with last=0, then 64'h8000_0000_0000_0000 with last=1; byte_ready_o=0 during PAD_EXTRA.
REQ-034 Test 3: 16 bytes with block_ready_i=0 held -> first block held stable, FSM enters HOLD, byte_ready_o=0 after byte 16; releasing block_ready_i drains both blocks back-to-back.
REQ-035 Test 4: resetb_i=1 asserted after 3 bytes of a message -> no block emitted; the next message 0xAA (last) -> 64'hAA80_0000_0000_0000.
REQ-036 Test 5: message of 1 byte 0x41 immediately followed by a message of 1 byte 0x42 -> blocks 64'h4180_0000_0000_0000 and 64'h4280_0000_0000_0000 on consecutive transfers.
REQ-037 Test 6: ASCON_PACKER_COUNT_EN defined, with tests 1 and 2 run in sequence -> block_count_o=3.
